// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants, sync polarity and decoder state enum.
// Used by the sync generator and by the receive-side sync decoder.
package vga_timing_pkg;

    localparam int H_TOTAL  = 800;
    localparam int H_ACTIVE = 640;
    localparam int H_START  = 144;
    localparam int V_TOTAL  = 525;
    localparam int V_ACTIVE = 480;
    localparam int V_START  = 35;

    // Asserted level of both syncs (0 = active-low).
    localparam logic SYNC_POL = 1'b0;

    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } vga_state_t;

    // 11-bit unsigned window test so start+len never wraps.
    function automatic logic in_window(
        input logic [10:0] val,
        input logic [10:0] start,
        input logic [10:0] len
    );
        return (val >= start) && (val < (start + len));
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Input register for one sync pin plus assertion-edge detector.
// Ports: clk, reset (async, high), i_pin (raw pin), o_edge (assertion pulse).
module sync_edge_det
    import vga_timing_pkg::*;
#(
    parameter logic P_POL = SYNC_POL
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_edge
);

    logic r_cur;
    logic r_prev;

    // Reset to the deasserted level so release never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur  <= ~P_POL;
            r_prev <= ~P_POL;
        end else begin
            r_cur  <= i_pin;
            r_prev <= r_cur;
        end
    end

    assign o_edge = (r_cur == P_POL) && (r_prev != P_POL);

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from sampled VGA sync/RGB pins and checks
// line/frame periods, reporting lock state and timing errors.
// Inputs : clk, reset (async, high), i_vga_h_sync, i_vga_v_sync, i_vga_rgb.
// Outputs: o_px_x/o_px_y/o_px_rgb/o_px_valid (pixel stream), o_frame_start,
//          o_locked, o_timing_err, o_err_count (saturating).
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int   P_H_TOTAL  = H_TOTAL,
    parameter int   P_H_ACTIVE = H_ACTIVE,
    parameter int   P_H_START  = H_START,
    parameter int   P_V_TOTAL  = V_TOTAL,
    parameter int   P_V_ACTIVE = V_ACTIVE,
    parameter int   P_V_START  = V_START,
    parameter logic P_SYNC_POL = SYNC_POL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_vga_h_sync,
    input  logic       i_vga_v_sync,
    input  logic [2:0] i_vga_rgb,
    output logic [9:0] o_px_x,
    output logic [9:0] o_px_y,
    output logic [2:0] o_px_rgb,
    output logic       o_px_valid,
    output logic       o_frame_start,
    output logic       o_locked,
    output logic       o_timing_err,
    output logic [7:0] o_err_count
);

    localparam logic [10:0] L_H_TOTAL  = 11'(P_H_TOTAL);
    localparam logic [10:0] L_H_ACTIVE = 11'(P_H_ACTIVE);
    localparam logic [10:0] L_H_START  = 11'(P_H_START);
    localparam logic [10:0] L_V_TOTAL  = 11'(P_V_TOTAL);
    localparam logic [10:0] L_V_ACTIVE = 11'(P_V_ACTIVE);
    localparam logic [10:0] L_V_START  = 11'(P_V_START);
    localparam logic [9:0]  L_X_OFF    = 10'(P_H_START);
    localparam logic [9:0]  L_Y_OFF    = 10'(P_V_START);

    logic       w_h_edge;
    logic       w_v_edge;
    logic [2:0] r_rgb;

    logic [9:0] r_hcnt;
    logic [9:0] r_lcnt;
    logic       r_h_ref;
    logic       r_bad;

    vga_state_t r_state;
    vga_state_t w_state_nxt;

    logic [10:0] w_hcnt_ext;
    logic [10:0] w_lcnt_ext;
    logic [10:0] w_v_cnt;
    logic        w_timeout;
    logic        w_h_mis;
    logic        w_v_mis;
    logic        w_err;
    logic        w_in_h;
    logic        w_in_v;
    logic        w_valid;

    logic [9:0] r_px_x;
    logic [9:0] r_px_y;
    logic [2:0] r_px_rgb;
    logic       r_px_valid;
    logic       r_frame_start;
    logic       r_timing_err;
    logic [7:0] r_err_count;

    sync_edge_det #(.P_POL(P_SYNC_POL)) u_h_det (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (i_vga_h_sync),
        .o_edge (w_h_edge)
    );

    sync_edge_det #(.P_POL(P_SYNC_POL)) u_v_det (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (i_vga_v_sync),
        .o_edge (w_v_edge)
    );

    // RGB shares the input stage with the sync pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rgb <= '0;
        else       r_rgb <= i_vga_rgb;
    end

    assign w_hcnt_ext = {1'b0, r_hcnt};
    assign w_lcnt_ext = {1'b0, r_lcnt};

    // A coincident hsync edge belongs to the frame that is ending.
    assign w_v_cnt = w_lcnt_ext + {10'd0, w_h_edge};

    // An arriving hsync edge proves the sync is alive, so it beats timeout.
    assign w_timeout = (r_hcnt == CNT_MAX) && !w_h_edge;

    assign w_h_mis = w_h_edge && r_h_ref &&
                     ((w_hcnt_ext + 11'd1) != L_H_TOTAL);
    assign w_v_mis = w_v_edge && (r_state != SEARCH) &&
                     (w_v_cnt != L_V_TOTAL);

    // H and V mismatch in one cycle collapse into a single error.
    assign w_err = (r_state != SEARCH) && (w_h_mis || w_v_mis) && !w_timeout;

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = SEARCH;
        end else begin
            unique case (r_state)
                SEARCH: begin
                    if (w_v_edge) w_state_nxt = MEASURE;
                end
                MEASURE: begin
                    if (w_v_edge && !(r_bad || w_h_mis || w_v_mis))
                        w_state_nxt = LOCKED;
                end
                LOCKED: begin
                    if (w_h_mis || w_v_mis) w_state_nxt = MEASURE;
                end
                default: w_state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= SEARCH;
        else       r_state <= w_state_nxt;
    end

    // r_bad remembers an H mismatch anywhere in the current frame, so a
    // frame that lost lock mid-way can never be the one that relocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hcnt  <= '0;
            r_lcnt  <= '0;
            r_h_ref <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            if (w_h_edge)
                r_hcnt <= '0;
            else if (r_hcnt != CNT_MAX)
                r_hcnt <= r_hcnt + 10'd1;

            if (w_v_edge)
                r_lcnt <= '0;
            else if (w_h_edge)
                r_lcnt <= r_lcnt + 10'd1;

            if (w_timeout)
                r_h_ref <= 1'b0;
            else if (w_h_edge)
                r_h_ref <= 1'b1;

            if (w_timeout || w_v_edge)
                r_bad <= 1'b0;
            else if (w_h_mis)
                r_bad <= 1'b1;
        end
    end

    assign w_in_h  = in_window(w_hcnt_ext, L_H_START, L_H_ACTIVE);
    assign w_in_v  = in_window(w_lcnt_ext, L_V_START, L_V_ACTIVE);
    assign w_valid = (r_state == LOCKED) && w_in_h && w_in_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_px_x        <= '0;
            r_px_y        <= '0;
            r_px_rgb      <= '0;
            r_px_valid    <= 1'b0;
            r_frame_start <= 1'b0;
            r_timing_err  <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_px_x        <= w_valid ? (r_hcnt - L_X_OFF) : '0;
            r_px_y        <= w_valid ? (r_lcnt - L_Y_OFF) : '0;
            r_px_rgb      <= w_valid ? r_rgb : '0;
            r_px_valid    <= w_valid;
            r_frame_start <= w_v_edge;
            r_timing_err  <= w_err;
            if (w_err && (r_err_count != 8'hFF))
                r_err_count <= r_err_count + 8'd1;
        end
    end

    assign o_px_x        = r_px_x;
    assign o_px_y        = r_px_y;
    assign o_px_rgb      = r_px_rgb;
    assign o_px_valid    = r_px_valid;
    assign o_frame_start = r_frame_start;
    assign o_locked      = (r_state == LOCKED);
    assign o_timing_err  = r_timing_err;
    assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 40x12 raster.
// Per-sample expectations are queued on drive and popped two clocks later.
module tb_vga_sync_decoder;

    localparam int   HT  = 40;
    localparam int   HA  = 20;
    localparam int   HS  = 8;
    localparam int   VT  = 12;
    localparam int   VA  = 6;
    localparam int   VS  = 3;
    localparam logic POL = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       h_pin;
    logic       v_pin;
    logic [2:0] rgb_pin;
    logic [9:0] o_px_x;
    logic [9:0] o_px_y;
    logic [2:0] o_px_rgb;
    logic       o_px_valid;
    logic       o_frame_start;
    logic       o_locked;
    logic       o_timing_err;
    logic [7:0] o_err_count;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .P_H_TOTAL  (HT),
        .P_H_ACTIVE (HA),
        .P_H_START  (HS),
        .P_V_TOTAL  (VT),
        .P_V_ACTIVE (VA),
        .P_V_START  (VS),
        .P_SYNC_POL (POL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_vga_h_sync  (h_pin),
        .i_vga_v_sync  (v_pin),
        .i_vga_rgb     (rgb_pin),
        .o_px_x        (o_px_x),
        .o_px_y        (o_px_y),
        .o_px_rgb      (o_px_rgb),
        .o_px_valid    (o_px_valid),
        .o_frame_start (o_frame_start),
        .o_locked      (o_locked),
        .o_timing_err  (o_timing_err),
        .o_err_count   (o_err_count)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] rgb;
        logic       v;
        logic       fs;
        logic       lk;
        logic       te;
        logic [7:0] ec;
    } obs_t;

    typedef struct packed {
        logic chk;
        obs_t o;
    } ent_t;

    typedef enum logic [1:0] {M_SEARCH, M_MEASURE, M_LOCKED} mst_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   te_seen  = 0;

    mst_t m_st;
    bit   m_href;
    bit   m_bad;
    bit   m_prev_vs;
    bit   m_fs;
    bit   m_te;
    int   m_prev_len;
    int   m_hcount;
    int   m_ec;

    function automatic obs_t cur_obs();
        obs_t o;
        o.x   = o_px_x;
        o.y   = o_px_y;
        o.rgb = o_px_rgb;
        o.v   = o_px_valid;
        o.fs  = o_frame_start;
        o.lk  = o_locked;
        o.te  = o_timing_err;
        o.ec  = o_err_count;
        return o;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st       = M_SEARCH;
        m_href     = 0;
        m_bad      = 0;
        m_prev_vs  = 0;
        m_fs       = 0;
        m_te       = 0;
        m_prev_len = HT;
        m_hcount   = 0;
        m_ec       = 0;
    endtask

    // Line-level model of the period checks and lock FSM.
    task automatic model_line_start(input int len, input bit vl);
        bit hmis;
        bit vmis;
        bit vedge;
        bit err;
        hmis  = m_href && (m_prev_len != HT);
        vedge = vl && !m_prev_vs;
        vmis  = vedge && (m_st != M_SEARCH) && (m_hcount + 1 != VT);
        err   = (m_st != M_SEARCH) && (hmis || vmis);
        case (m_st)
            M_SEARCH:  if (vedge) m_st = M_MEASURE;
            M_MEASURE: if (vedge && !(m_bad || hmis || vmis)) m_st = M_LOCKED;
            default:   if (hmis || vmis) m_st = M_MEASURE;
        endcase
        m_bad      = vedge ? 1'b0 : (m_bad | hmis);
        m_hcount   = vedge ? 0 : m_hcount + 1;
        m_href     = 1;
        m_prev_len = len;
        m_prev_vs  = vl;
        if (err && m_ec != 255) m_ec++;
        m_fs = vedge;
        m_te = err;
    endtask

    task automatic tick(input ent_t e);
        ent_t f;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (o_timing_err) te_seen++;
        if (q.size() >= 2) begin
            f = q.pop_front();
            if (f.chk) check("scoreboard", 64'(cur_obs()), 64'(f.o));
        end
    endtask

    // long_ln: line index made HT+1 long (-2 = every line, -1 = none).
    // Vsync is asserted for lines 0 and 1; hsync for offsets 0..3.
    // A sample k clocks after the hsync assertion sample sees hcnt = k-1.
    task automatic drive_frame(input int nlines, input int long_ln,
                               input int stop_ln, input int stop_k);
        for (int ln = 0; ln < nlines; ln++) begin
            int len;
            bit vl;
            len = (long_ln == ln || long_ln == -2) ? HT + 1 : HT;
            vl  = (ln < 2);
            for (int k = 0; k < len; k++) begin
                ent_t e;
                int   hx;
                bit   win;
                if (ln == stop_ln && k == stop_k) return;
                if (k == 0) model_line_start(len, vl);
                h_pin   = (k < 4) ? POL : ~POL;
                v_pin   = vl ? POL : ~POL;
                rgb_pin = 3'((k + 3 * ln) & 7);
                hx  = k - 1;
                win = (m_st == M_LOCKED) && (k >= 1) && (hx >= HS) &&
                      (hx < HS + HA) && (ln >= VS) && (ln < VS + VA);
                e.chk   = 1'b1;
                e.o.x   = win ? 10'(hx - HS) : 10'd0;
                e.o.y   = win ? 10'(ln - VS) : 10'd0;
                e.o.rgb = win ? rgb_pin : 3'd0;
                e.o.v   = win;
                e.o.fs  = (k == 0) && m_fs;
                e.o.te  = (k == 0) && m_te;
                e.o.lk  = (m_st == M_LOCKED);
                e.o.ec  = 8'(m_ec);
                tick(e);
            end
        end
    endtask

    initial begin
        ent_t idle_e;
        idle_e  = '0;
        reset   = 1'b1;
        h_pin   = ~POL;
        v_pin   = ~POL;
        rgb_pin = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(cur_obs()), 64'd0);
        reset = 1'b0;

        repeat (3) drive_frame(VT, -1, -1, 0);
        check("locked_nominal", 64'(o_locked), 64'd1);
        check("errcnt_nominal", 64'(o_err_count), 64'd0);

        drive_frame(VT, 5, -1, 0);
        check("locked_after_long_line", 64'(o_locked), 64'd0);
        check("errcnt_long_line", 64'(o_err_count), 64'd1);
        drive_frame(VT, -1, -1, 0);
        check("locked_dirty_frame", 64'(o_locked), 64'd0);
        drive_frame(VT, -1, -1, 0);
        check("relock_clean_frame", 64'(o_locked), 64'd1);

        drive_frame(VT - 1, -1, -1, 0);
        drive_frame(VT, -1, -1, 0);
        check("locked_after_vmis", 64'(o_locked), 64'd0);
        check("errcnt_vmis", 64'(o_err_count), 64'd2);
        drive_frame(VT, -1, -1, 0);
        check("relock_after_vmis", 64'(o_locked), 64'd1);

        te_seen = 0;
        h_pin   = ~POL;
        v_pin   = ~POL;
        rgb_pin = '0;
        repeat (1100) tick(idle_e);
        m_st      = M_SEARCH;
        m_href    = 0;
        m_bad     = 0;
        m_prev_vs = 0;
        check("locked_timeout", 64'(o_locked), 64'd0);
        check("no_err_timeout", 64'(te_seen), 64'd0);
        check("errcnt_timeout", 64'(o_err_count), 64'd2);
        drive_frame(VT, -1, -1, 0);
        drive_frame(VT, -1, -1, 0);
        check("relock_after_timeout", 64'(o_locked), 64'd1);

        drive_frame(VT, -1, 5, 20);
        reset = 1'b1;
        #1;
        check("reset_midline", 64'(cur_obs()), 64'd0);
        q.delete();
        h_pin = ~POL;
        v_pin = ~POL;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        drive_frame(VT, -1, -1, 0);
        check("no_lock_one_vsync", 64'(o_locked), 64'd0);
        drive_frame(VT, -1, -1, 0);
        check("relock_two_vsync", 64'(o_locked), 64'd1);
        check("errcnt_after_reset", 64'(o_err_count), 64'd0);

        repeat (26) drive_frame(VT, -2, -1, 0);
        check("errcnt_saturate", 64'(o_err_count), 64'd255);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
